des_key_schedule: RTL and testbench

- Generates the sixteen 48-bit DES round keys from one 64-bit key, one key per request.
- Sits directly upstream of the round datapath and drives its rKey input; round and fKg tell the sequencer that a key is ready.
- Performs PC-1, per-round C/D rotation and PC-2 internally.
- Supports encryption (keys K1..K16) and decryption (keys K16..K1) from the same loaded key.

---
 rtl/des_key_schedule_if.sv | 22 ++
 rtl/des_key_schedule.sv | 134 +++++++++++++
 tb/tb_des_key_schedule.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_if.sv
// Request/response bundle between the DES round sequencer (master) and the key schedule (slave).
interface des_key_schedule_if;
    logic        iLd;
    logic        iKg;
    logic        decrypt;
    logic [63:0] key;
    logic [47:0] rKey;
    logic [4:0]  round;
    logic        fLd;
    logic        fKg;
    logic        fDone;

    modport master (
        output iLd, iKg, decrypt, key,
        input  rKey, round, fLd, fKg, fDone
    );

    modport slave (
        input  iLd, iKg, decrypt, key,
        output rKey, round, fLd, fKg, fDone
    );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on load, then one rotated/PC-2 round key per request,
// in encryption (K1..K16) or decryption (K16..K1) order.
module des_key_schedule (
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READY, DONE} state_t;

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Table entries are 1-based DES bit numbers counted from the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            o[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            o[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        end
        return o;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] v, input logic right,
                                        input logic [1:0] amt);
        logic [27:0] o;
        case ({right, amt})
            3'b001:  o = {v[26:0], v[27]};
            3'b010:  o = {v[25:0], v[27:26]};
            3'b101:  o = {v[0], v[27:1]};
            3'b110:  o = {v[1:0], v[27:2]};
            default: o = v;
        endcase
        return o;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_mode;
    logic [4:0]  r_cnt;
    logic [47:0] r_rkey;
    logic        r_fld;
    logic        r_fkg;
    logic [4:0]  w_r;
    logic [1:0]  w_amt;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic        w_gen;

    // Decryption walks the encryption rotations backwards: K16 uses C0/D0 unshifted.
    always_comb begin
        w_r   = r_cnt + 5'd1;
        w_amt = 2'd2;
        if (!r_mode) begin
            if (w_r == 5'd1 || w_r == 5'd2 || w_r == 5'd9 || w_r == 5'd16) w_amt = 2'd1;
        end else begin
            if (w_r == 5'd1) w_amt = 2'd0;
            else if (w_r == 5'd2 || w_r == 5'd9 || w_r == 5'd16) w_amt = 2'd1;
        end
        w_c_rot = rot(r_c, r_mode, w_amt);
        w_d_rot = rot(r_d, r_mode, w_amt);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gen       = 1'b0;
        if (bus.iLd) begin
            w_state_nxt = READY;
        end else if (r_state == READY && bus.iKg) begin
            w_gen = 1'b1;
            if (w_r == 5'd16) w_state_nxt = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c    <= '0;
            r_d    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_rkey <= '0;
            r_fld  <= 1'b0;
            r_fkg  <= 1'b0;
        end else begin
            r_fld <= 1'b0;
            r_fkg <= 1'b0;
            if (bus.iLd) begin
                {r_c, r_d} <= pc1(bus.key);
                r_mode     <= bus.decrypt;
                r_cnt      <= '0;
                r_rkey     <= '0;
                r_fld      <= 1'b1;
            end else if (w_gen) begin
                r_c    <= w_c_rot;
                r_d    <= w_d_rot;
                r_rkey <= pc2({w_c_rot, w_d_rot});
                r_cnt  <= w_r;
                r_fkg  <= 1'b1;
            end
        end
    end

    assign bus.rKey  = r_rkey;
    assign bus.round = r_cnt;
    assign bus.fLd   = r_fld;
    assign bus.fKg   = r_fkg;
    assign bus.fDone = (r_state == DONE);
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 round-key vectors.
module tb_des_key_schedule;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [55:0] PC1_A = 56'hF0CCAAF556678F;

    logic [47:0] K [1:16];
    logic [63:0] key_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rKey"}, 64'(bus.rKey), 64'h0);
        check({tag, "_round"}, 64'(bus.round), 64'h0);
        check({tag, "_fLd"}, 64'(bus.fLd), 64'h0);
        check({tag, "_fKg"}, 64'(bus.fKg), 64'h0);
        check({tag, "_fDone"}, 64'(bus.fDone), 64'h0);
    endtask

    task automatic load(input logic [63:0] k, input logic dec);
        bus.key     = k;
        bus.decrypt = dec;
        bus.iLd     = 1'b1;
        tick();
        bus.iLd = 1'b0;
        check("load_fLd", 64'(bus.fLd), 64'h1);
        check("load_round", 64'(bus.round), 64'h0);
        check("load_rKey", 64'(bus.rKey), 64'h0);
        check("load_fDone", 64'(bus.fDone), 64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        K = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
              48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
              48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
              48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        key_b = KEY_A ^ 64'h0100_0000_0000_0001;

        bus.iLd = 1'b0; bus.iKg = 1'b0; bus.decrypt = 1'b0; bus.key = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        bus.iKg = 1'b1;
        tick();
        bus.iKg = 1'b0;
        check("idle_ikg_fKg", 64'(bus.fKg), 64'h0);
        check("idle_ikg_round", 64'(bus.round), 64'h0);

        // Encryption, back-to-back requests
        load(KEY_A, 1'b0);
        check("pc1_probe", {8'h0, dut.r_c, dut.r_d}, {8'h0, PC1_A});
        bus.iKg = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("enc_fKg_%0d", i), 64'(bus.fKg), 64'h1);
            check($sformatf("enc_round_%0d", i), 64'(bus.round), 64'(i));
            check($sformatf("enc_rKey_%0d", i), 64'(bus.rKey), 64'(K[i]));
            check($sformatf("enc_fDone_%0d", i), 64'(bus.fDone), 64'(i == 16));
            if (i == 1) check("enc_fLd_cleared", 64'(bus.fLd), 64'h0);
        end
        bus.iKg = 1'b0;
        tick();
        check("enc_after_fKg", 64'(bus.fKg), 64'h0);
        check("enc_after_fDone", 64'(bus.fDone), 64'h1);
        check("enc_wrap_probe", {8'h0, dut.r_c, dut.r_d}, {8'h0, PC1_A});

        bus.iKg = 1'b1;
        tick();
        bus.iKg = 1'b0;
        check("overflow_fKg", 64'(bus.fKg), 64'h0);
        check("overflow_round", 64'(bus.round), 64'd16);
        check("overflow_rKey", 64'(bus.rKey), 64'(K[16]));
        check("overflow_fDone", 64'(bus.fDone), 64'h1);

        // Decryption; decrypt toggles mid-schedule and must be ignored
        load(KEY_A, 1'b1);
        bus.iKg = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            bus.decrypt = ~bus.decrypt;
            tick();
            check($sformatf("dec_fKg_%0d", i), 64'(bus.fKg), 64'h1);
            check($sformatf("dec_round_%0d", i), 64'(bus.round), 64'(i));
            check($sformatf("dec_rKey_%0d", i), 64'(bus.rKey), 64'(K[17 - i]));
            check($sformatf("dec_fDone_%0d", i), 64'(bus.fDone), 64'(i == 16));
        end
        bus.iKg = 1'b0;

        // Spaced requests with hold, then reset mid-schedule after round 5
        load(KEY_A, 1'b0);
        for (int unsigned i = 1; i <= 5; i++) begin
            bus.iKg = 1'b1;
            tick();
            bus.iKg = 1'b0;
            check($sformatf("spc_rKey_%0d", i), 64'(bus.rKey), 64'(K[i]));
            for (int unsigned j = 0; j < 3; j++) begin
                tick();
                check($sformatf("hold_fKg_%0d_%0d", i, j), 64'(bus.fKg), 64'h0);
                check($sformatf("hold_round_%0d_%0d", i, j), 64'(bus.round), 64'(i));
                check($sformatf("hold_rKey_%0d_%0d", i, j), 64'(bus.rKey), 64'(K[i]));
            end
        end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        check("midrst_cd", {8'h0, dut.r_c, dut.r_d}, 64'h0);
        bus.iKg = 1'b1;
        tick();
        bus.iKg = 1'b0;
        check("midrst_ikg_fKg", 64'(bus.fKg), 64'h0);
        check("midrst_ikg_round", 64'(bus.round), 64'h0);

        // Priority of iLd over iKg at round 7, reloading a parity-variant key
        load(KEY_A, 1'b0);
        bus.iKg = 1'b1;
        for (int unsigned i = 1; i <= 7; i++) tick();
        check("pri_pre_round", 64'(bus.round), 64'd7);
        bus.key = key_b;
        bus.iLd = 1'b1;
        tick();
        bus.iLd = 1'b0;
        check("pri_fLd", 64'(bus.fLd), 64'h1);
        check("pri_fKg", 64'(bus.fKg), 64'h0);
        check("pri_round", 64'(bus.round), 64'h0);
        check("pri_rKey", 64'(bus.rKey), 64'h0);
        for (int unsigned i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("par_rKey_%0d", i), 64'(bus.rKey), 64'(K[i]));
            check($sformatf("par_round_%0d", i), 64'(bus.round), 64'(i));
        end
        bus.iKg = 1'b0;
        tick();
        check("par_fDone", 64'(bus.fDone), 64'h1);
        check("par_wrap_probe", {8'h0, dut.r_c, dut.r_d}, {8'h0, PC1_A});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
